// File: rtl/approx_pkg.sv
// approx_pkg -- shared definitions for the approximate dot-product accumulator.
//   PROD_W     : width of one approximate 8x8 multiplier product
//   DEF_LEN    : default number of products per frame
//   DEF_ACC_W  : default accumulator / result width
//   state_t    : frame controller states (ACC = collecting, HOLD = result held)
package approx_pkg;

  localparam int PROD_W    = 16;
  localparam int DEF_LEN   = 8;
  localparam int DEF_ACC_W = 24;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/approx_dot_acc_add.sv
// approx_acc_add -- combinational accumulate step: acc + zero-extended prod.
// Build option APPROX_ACC_SAT_EN:
//   defined   : any carry out of ACC_W, or an already-set sticky flag, clamps
//               the sum to all-ones and raises ovf_out (sticky for the frame).
//   undefined : the sum wraps modulo 2^ACC_W and ovf_out is 0.
// Ports:
//   acc     in  ACC_W   running sum
//   prod    in  PROD_W  product to add (unsigned)
//   ovf_in  in  1       sticky overflow flag of the current frame
//   sum     out ACC_W   next running sum
//   ovf_out out 1       next sticky overflow flag
module approx_acc_add
  import approx_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  input  logic              ovf_in,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf_out
);

  // One extra bit captures the carry out of the accumulator width.
  logic [ACC_W:0] sum_ext;

  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

`ifdef APPROX_ACC_SAT_EN
  // Once the frame has overflowed it stays clamped, even if later adds would
  // not carry on their own.
  assign ovf_out = ovf_in | sum_ext[ACC_W];
  assign sum     = ovf_out ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  logic unused_ovf;

  assign sum        = sum_ext[ACC_W-1:0];
  assign ovf_out    = 1'b0;
  assign unused_ovf = ^{ovf_in, sum_ext[ACC_W]};
`endif

endmodule

// File: rtl/approx_dot_acc.sv
// approx_dot_acc -- accumulates LEN approximate-multiplier products per frame
// and presents the frame sum through a valid/ready output handshake.
// Build option APPROX_ACC_SAT_EN selects saturating accumulation with an
// overflow flag; without it the sum wraps and out_ovf is 0.
// Ports:
//   clk        in  1       clock, rising edge
//   rst_n      in  1       synchronous active-low reset
//   clear      in  1       synchronous frame flush (beats accept/handshake)
//   in_valid   in  1       in_prod is valid
//   in_ready   out 1       product accepted this cycle when in_valid=1
//   in_prod    in  16      unsigned product
//   out_valid  out 1       out_sum / out_ovf valid
//   out_ready  in  1       consumer takes the result
//   out_sum    out ACC_W   frame sum
//   out_ovf    out 1       frame sum overflowed ACC_W
module approx_dot_acc
  import approx_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf_flag;
  logic             ovf_nxt;
  logic             accept;

  approx_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc    (acc),
    .prod   (in_prod),
    .ovf_in (ovf_flag),
    .sum    (sum),
    .ovf_out(ovf_nxt)
  );

  assign accept = in_valid & in_ready;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
    if (clear) state_nxt = ACC;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // Datapath. The result registers only load on the final accept of a frame,
  // so they stay frozen throughout HOLD and across the following ACC phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      out_sum  <= '0;
      out_ovf  <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else if (accept) begin
      if (cnt == LAST) begin
        out_sum  <= sum;
        out_ovf  <= ovf_nxt;
        acc      <= '0;
        cnt      <= '0;
        ovf_flag <= 1'b0;
      end else begin
        acc      <= sum;
        cnt      <= cnt + 1'b1;
        ovf_flag <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_approx_dot_acc.sv
// tb_approx_dot_acc -- directed bench for approx_dot_acc.
// dut_a: LEN=8, ACC_W=24.  dut_b: LEN=2, ACC_W=16 (overflow corner).
// Expected overflow results follow APPROX_ACC_SAT_EN as compiled.
module tb_approx_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic        out_ovf;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_in_prod;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [15:0] b_out_sum;
  logic        b_out_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_dot_acc #(.LEN(8), .ACC_W(24)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf)
  );

  approx_dot_acc #(.LEN(2), .ACC_W(16)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (1'b0),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_prod  (b_in_prod),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_sum  (b_out_sum),
    .out_ovf  (b_out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p);
    in_valid = 1'b1;
    in_prod  = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] p);
    b_in_valid = 1'b1;
    b_in_prod  = p;
    step();
    b_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_prod     = '0;
    out_ready   = 1'b1;
    b_in_valid  = 1'b0;
    b_in_prod   = '0;
    b_out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Eight full-scale products, latency of one cycle from the last accept
    for (int i = 0; i < 7; i++) push(16'hFFFF);
    check("full_valid_before_last", 32'(out_valid), 32'd0);
    push(16'hFFFF);
    check("full_valid",  32'(out_valid), 32'd1);
    check("full_sum",    32'(out_sum),   32'h07FFF8);
    check("full_ovf",    32'(out_ovf),   32'd0);
    check("full_in_rdy", 32'(in_ready),  32'd0);
    step();
    check("full_hs_valid", 32'(out_valid), 32'd0);
    check("full_hs_ready", 32'(in_ready),  32'd1);

    // Back-pressure: result held for 5 cycles while upstream keeps in_valid
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    in_valid = 1'b1;
    in_prod  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum",   32'(out_sum),   32'h24);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_hs_valid", 32'(out_valid), 32'd0);
    check("bp_hs_ready", 32'(in_ready),  32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) push(16'h0001);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_sum",   32'(out_sum),   32'h123B);
    step();

    // Clear mid-frame, then a fresh frame of 0x0010
    for (int i = 0; i < 3; i++) push(16'h0100);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0010);
    check("clr_mid_valid", 32'(out_valid), 32'd1);
    check("clr_mid_sum",   32'(out_sum),   32'h80);
    step();

    // Clear coinciding with the final accept
    for (int i = 0; i < 7; i++) push(16'h0005);
    clear = 1'b1;
    push(16'h0005);
    clear = 1'b0;
    check("clr_last_valid", 32'(out_valid), 32'd0);
    check("clr_last_acc",   32'(dut_a.acc), 32'd0);
    check("clr_last_cnt",   32'(dut_a.cnt), 32'd0);
    step();
    check("clr_last_valid2", 32'(out_valid), 32'd0);
    for (int i = 0; i < 7; i++) push(16'h0002);
    check("clr_after_early", 32'(out_valid), 32'd0);
    push(16'h0002);
    check("clr_after_valid", 32'(out_valid), 32'd1);
    check("clr_after_sum",   32'(out_sum),   32'h10);
    step();

    // Reset while holding a result
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0003);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_sum",   32'(out_sum),   32'h18);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_sum",   32'(out_sum),   32'd0);
    check("hold_rst_ready", 32'(in_ready),  32'd1);
    step();
    check("hold_rst_valid2", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // Narrow accumulator overflow: 0xFFFF + 0x0001 in 16 bits
    push_b(16'hFFFF);
    check("ovf_valid_early", 32'(b_out_valid), 32'd0);
    push_b(16'h0001);
    check("ovf_valid", 32'(b_out_valid), 32'd1);
`ifdef APPROX_ACC_SAT_EN
    check("ovf_sum", 32'(b_out_sum), 32'hFFFF);
    check("ovf_flag", 32'(b_out_ovf), 32'd1);
`else
    check("ovf_sum", 32'(b_out_sum), 32'h0000);
    check("ovf_flag", 32'(b_out_ovf), 32'd0);
`endif
    step();
    push_b(16'h0003);
    push_b(16'h0004);
    check("ovf_next_sum",  32'(b_out_sum), 32'h0007);
    check("ovf_next_flag", 32'(b_out_ovf), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
